// File: rtl/seq_engine.sv
// seq_engine: parametrised instruction sequencer.
// Instructions enter a small FIFO through a valid/ready port and execute in
// order against an internal register file. SEND serialises a full register
// onto a TX_W-wide UART strobe interface and stalls on i_tx_busy.
module seq_engine #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NREG       = 4,
  parameter int unsigned TX_W       = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MSB_FIRST  = 0,
  localparam int unsigned RN_W      = $clog2(NREG),
  localparam int unsigned INST_W    = 2 + 3*RN_W,
  localparam int unsigned IMM_W     = INST_W - 2 - RN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_inst_valid,
  output logic              o_inst_ready,
  output logic [TX_W-1:0]   o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_busy,
  output logic              o_idle
);

  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned NBYTES = DATA_W / TX_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;
  typedef enum logic [1:0] {OP_PUSH, OP_ADD, OP_MULT, OP_SEND} op_e;

  // Instruction FIFO storage and pointers (extra MSB distinguishes full/empty)
  logic [INST_W-1:0] fifo_q [FIFO_DEPTH];
  logic [INST_W-1:0] fifo_d [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;

  // Register file and SEND datapath
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TX_W-1:0]   tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  state_e            state_q, state_d;

  logic              fifo_empty;
  logic              fifo_full;
  logic              push;
  logic [INST_W-1:0] head;
  op_e               head_op;
  logic [RN_W-1:0]   head_ra, head_rb, head_rc;
  logic [IMM_W-1:0]  head_imm;
  logic [TX_W-1:0]   cur_byte;
  logic [DATA_W-1:0] shift_nxt;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = i_inst_valid & ~fifo_full;

  assign head     = fifo_q[rd_ptr_q[AW-1:0]];
  assign head_op  = op_e'(head[INST_W-1 -: 2]);
  assign head_ra  = head[INST_W-3 -: RN_W];
  assign head_rb  = head[INST_W-3-RN_W -: RN_W];
  assign head_rc  = head[RN_W-1:0];
  assign head_imm = head[IMM_W-1:0];

  // Byte order is fixed at elaboration: take from the top and shift left,
  // or take from the bottom and shift right.
  assign cur_byte  = (MSB_FIRST != 0) ? shift_q[DATA_W-1 -: TX_W] : shift_q[TX_W-1:0];
  assign shift_nxt = (MSB_FIRST != 0) ? (shift_q << TX_W) : (shift_q >> TX_W);

  assign o_inst_ready = ~fifo_full;
  assign o_tx_data    = tx_data_q;
  assign o_tx_valid   = tx_valid_q;
  assign o_idle       = fifo_empty && (state_q == ST_IDLE);

  // FIFO write side: accept whenever not full, regardless of a same-cycle pop
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q[AW-1:0]] = i_inst;
      wr_ptr_d                 = wr_ptr_q + PTR_ONE;
    end
  end

  // Sequencer: pop/execute in IDLE, emit one byte per SEND->GAP pair
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    regs_d     = regs_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          case (head_op)
            OP_PUSH: regs_d[head_ra] = DATA_W'(head_imm);
            OP_ADD:  regs_d[head_rc] = regs_q[head_ra] + regs_q[head_rb];
            OP_MULT: regs_d[head_rc] = regs_q[head_ra] * regs_q[head_rb];
            default: begin
              shift_d = regs_q[head_ra];
              cnt_d   = CNT_W'(NBYTES);
              state_d = ST_SEND;
            end
          endcase
        end
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          tx_data_d  = cur_byte;
          tx_valid_d = 1'b1;
          shift_d    = shift_nxt;
          cnt_d      = cnt_q - CNT_ONE;
          state_d    = ST_GAP;
        end
      end
      ST_GAP: begin
        // busy is deliberately not sampled here: the strobe is still high
        state_d = (cnt_q != '0) ? ST_SEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      for (int unsigned i = 0; i < NREG; i++)       regs_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      fifo_q     <= fifo_d;
      regs_q     <= regs_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_seq_engine.sv
// Directed testbench for seq_engine: a default instance (16-bit, LSB first)
// and a 32-bit, 8-register, MSB-first instance.
module tb_seq_engine;

  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_MULT = 2'd2;
  localparam logic [1:0] OP_SEND = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Instance A: defaults
  logic        rst_a;
  logic [7:0]  inst_a;
  logic        inst_valid_a;
  logic        ready_a;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a;
  logic        busy_a;
  logic        idle_a;

  // Instance B: DATA_W=32, NREG=8, MSB_FIRST=1
  logic        rst_b;
  logic [10:0] inst_b;
  logic        inst_valid_b;
  logic        ready_b;
  logic [7:0]  tx_data_b;
  logic        tx_valid_b;
  logic        busy_b;
  logic        idle_b;

  seq_engine dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .i_inst       (inst_a),
    .i_inst_valid (inst_valid_a),
    .o_inst_ready (ready_a),
    .o_tx_data    (tx_data_a),
    .o_tx_valid   (tx_valid_a),
    .i_tx_busy    (busy_a),
    .o_idle       (idle_a)
  );

  seq_engine #(.DATA_W(32), .NREG(8), .MSB_FIRST(1)) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .i_inst       (inst_b),
    .i_inst_valid (inst_valid_b),
    .o_inst_ready (ready_b),
    .o_tx_data    (tx_data_b),
    .o_tx_valid   (tx_valid_b),
    .i_tx_busy    (busy_b),
    .o_idle       (idle_b)
  );

  // Strobe capture with the cycle count of the edge that raised it
  logic [7:0]  bytes_a [$];
  int unsigned stamp_a [$];
  logic [7:0]  bytes_b [$];
  int unsigned stamp_b [$];

  always @(negedge clk) begin
    if (tx_valid_a) begin
      bytes_a.push_back(tx_data_a);
      stamp_a.push_back(cyc);
    end
    if (tx_valid_b) begin
      bytes_b.push_back(tx_data_b);
      stamp_b.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the falling edge (after the strobe monitor ran)
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] ia(input logic [1:0] op, input logic [1:0] ra,
                                    input logic [1:0] rb, input logic [1:0] rc);
    return {op, ra, rb, rc};
  endfunction

  function automatic logic [7:0] pa(input logic [1:0] ra, input logic [3:0] imm);
    return {OP_PUSH, ra, imm};
  endfunction

  function automatic logic [10:0] pb(input logic [2:0] ra, input logic [5:0] imm);
    return {OP_PUSH, ra, imm};
  endfunction

  function automatic logic [10:0] sb(input logic [2:0] ra);
    return {OP_SEND, ra, 6'd0};
  endfunction

  task automatic issue_a(input logic [7:0] w);
    int n = 0;
    inst_a       = w;
    inst_valid_a = 1'b1;
    while (!ready_a && n < 300) begin
      step();
      n++;
    end
    chk("issue_a_ready", ready_a, 1);
    step();
    inst_valid_a = 1'b0;
  endtask

  task automatic issue_b(input logic [10:0] w);
    int n = 0;
    inst_b       = w;
    inst_valid_b = 1'b1;
    while (!ready_b && n < 300) begin
      step();
      n++;
    end
    chk("issue_b_ready", ready_b, 1);
    step();
    inst_valid_b = 1'b0;
  endtask

  task automatic wait_a(input int n);
    int k = 0;
    while (bytes_a.size() < n && k < 400) begin
      step();
      k++;
    end
    chk("strobe_wait_a", 32'(bytes_a.size() >= n), 1);
  endtask

  task automatic wait_b(input int n);
    int k = 0;
    while (bytes_b.size() < n && k < 400) begin
      step();
      k++;
    end
    chk("strobe_wait_b", 32'(bytes_b.size() >= n), 1);
  endtask

  logic [7:0] words [8];
  logic [7:0] exp4  [4];

  initial begin
    int          base;
    int          idx;
    int unsigned acc_cyc;
    int unsigned acc5;

    rst_a = 1'b0; inst_a = '0; inst_valid_a = 1'b0; busy_a = 1'b0;
    rst_b = 1'b0; inst_b = '0; inst_valid_b = 1'b0; busy_b = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_tx_valid", tx_valid_a, 0);
    chk("rst_tx_data",  tx_data_a,  0);
    chk("rst_ready",    ready_a,    1);
    chk("rst_idle",     idle_a,     1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    chk("post_rst_idle",  idle_a,     1);
    chk("post_rst_valid", tx_valid_a, 0);

    // 5 + 3 = 8, sent LSB first
    issue_a(pa(2'd1, 4'd5));
    issue_a(pa(2'd2, 4'd3));
    issue_a(ia(OP_ADD, 2'd1, 2'd2, 2'd3));
    issue_a(ia(OP_SEND, 2'd3, 2'd0, 2'd0));
    acc_cyc = cyc;
    wait_a(2);
    chk("t1_byte0",   bytes_a[0], 8'h08);
    chk("t1_byte1",   bytes_a[1], 8'h00);
    chk("t1_spacing", stamp_a[1] - stamp_a[0], 2);
    chk("t1_latency", stamp_a[0] - acc_cyc, 2);

    // Build 0xFFFF = 255*257, then 0xFFFF+0xFFFF wraps to 0xFFFE
    base = bytes_a.size();
    issue_a(pa(2'd0, 4'd15));
    issue_a(pa(2'd1, 4'd2));
    issue_a(ia(OP_ADD,  2'd0, 2'd1, 2'd2));   // r2 = 17
    issue_a(ia(OP_MULT, 2'd2, 2'd0, 2'd3));   // r3 = 255
    issue_a(ia(OP_ADD,  2'd3, 2'd1, 2'd3));   // r3 = 257
    issue_a(ia(OP_MULT, 2'd2, 2'd0, 2'd2));   // r2 = 255
    issue_a(ia(OP_MULT, 2'd2, 2'd3, 2'd1));   // r1 = 0xFFFF
    issue_a(ia(OP_ADD,  2'd1, 2'd1, 2'd0));   // r0 = 0xFFFE
    issue_a(ia(OP_SEND, 2'd0, 2'd0, 2'd0));
    wait_a(base + 2);
    chk("t2_add_b0", bytes_a[base],     8'hFE);
    chk("t2_add_b1", bytes_a[base + 1], 8'hFF);
    repeat (3) step();
    chk("t2_data_hold",  tx_data_a,  8'hFF);
    chk("t2_valid_low",  tx_valid_a, 0);
    chk("t2_idle_after", idle_a,     1);

    // 0xFF00 * 0x0100 truncates to 0
    base = bytes_a.size();
    issue_a(pa(2'd0, 4'd8));
    issue_a(ia(OP_ADD,  2'd0, 2'd0, 2'd0));   // r0 = 16
    issue_a(ia(OP_MULT, 2'd0, 2'd0, 2'd0));   // r0 = 256
    issue_a(ia(OP_MULT, 2'd2, 2'd0, 2'd1));   // r1 = 0xFF00
    issue_a(ia(OP_MULT, 2'd1, 2'd0, 2'd3));   // r3 = 0
    issue_a(ia(OP_SEND, 2'd3, 2'd0, 2'd0));
    issue_a(ia(OP_SEND, 2'd1, 2'd0, 2'd0));
    wait_a(base + 4);
    chk("t2_mul_b0", bytes_a[base],     8'h00);
    chk("t2_mul_b1", bytes_a[base + 1], 8'h00);
    chk("t2_mul_b2", bytes_a[base + 2], 8'h00);
    chk("t2_mul_b3", bytes_a[base + 3], 8'hFF);

    // Busy stall: no strobe while busy, one cycle after release
    base   = bytes_a.size();
    busy_a = 1'b1;
    issue_a(ia(OP_SEND, 2'd1, 2'd0, 2'd0));
    repeat (20) step();
    chk("t3_stall_count", bytes_a.size() - base, 0);
    chk("t3_stall_valid", tx_valid_a, 0);
    busy_a = 1'b0;
    step();
    chk("t3_first_strobe", bytes_a.size() - base, 1);
    chk("t3_byte0", bytes_a[base], 8'h00);
    busy_a = 1'b1;
    repeat (6) step();
    chk("t3_second_waits", bytes_a.size() - base, 1);
    busy_a = 1'b0;
    step();
    chk("t3_second_strobe", bytes_a.size() - base, 2);
    chk("t3_byte1", bytes_a[base + 1], 8'hFF);

    // Stream 8 instructions while a SEND is stalled
    words = '{pa(2'd0, 4'd1), pa(2'd1, 4'd2),
              ia(OP_ADD,  2'd0, 2'd1, 2'd2),   // r2 = 3
              ia(OP_ADD,  2'd2, 2'd2, 2'd3),   // r3 = 6
              ia(OP_MULT, 2'd3, 2'd2, 2'd0),   // r0 = 0x12
              ia(OP_ADD,  2'd0, 2'd1, 2'd1),   // r1 = 0x14
              ia(OP_SEND, 2'd0, 2'd0, 2'd0),
              ia(OP_SEND, 2'd1, 2'd0, 2'd0)};
    base   = bytes_a.size();
    busy_a = 1'b1;
    issue_a(ia(OP_SEND, 2'd1, 2'd0, 2'd0));
    repeat (3) step();
    chk("t4_not_idle", idle_a, 0);
    idx          = 0;
    acc5         = 0;
    inst_a       = words[0];
    inst_valid_a = 1'b1;
    for (int c = 0; c < 100 && idx < 8; c++) begin
      if (c == 12) busy_a = 1'b0;
      if (ready_a) begin
        step();
        idx++;
        if (idx == 4) chk("t4_full_after_4", ready_a, 0);
        if (idx == 5) acc5 = cyc;
        if (idx < 8) inst_a = words[idx];
      end else begin
        step();
      end
    end
    inst_valid_a = 1'b0;
    chk("t4_all_accepted", idx, 8);
    wait_a(base + 6);
    chk("t4_resume_timing", acc5, stamp_a[base + 1] + 3);
    exp4 = '{8'h12, 8'h00, 8'h14, 8'h00};
    chk("t4_stall_b0", bytes_a[base],     8'h00);
    chk("t4_stall_b1", bytes_a[base + 1], 8'hFF);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_stream_b%0d", i), bytes_a[base + 2 + i], exp4[i]);

    // SEND captures at pop; a queued PUSH to the same register cannot alter it
    base = bytes_a.size();
    issue_a(ia(OP_SEND, 2'd2, 2'd0, 2'd0));
    issue_a(pa(2'd2, 4'd7));
    issue_a(ia(OP_SEND, 2'd2, 2'd0, 2'd0));
    wait_a(base + 4);
    exp4 = '{8'h03, 8'h00, 8'h07, 8'h00};
    for (int i = 0; i < 4; i++) chk($sformatf("t5_b%0d", i), bytes_a[base + i], exp4[i]);

    // Instance B: MSB first, reset mid-transfer
    issue_b(pb(3'd5, 6'd12));
    issue_b(sb(3'd5));
    issue_b(sb(3'd5));
    wait_b(2);
    rst_b = 1'b0;
    chk("t6_b0", bytes_b[0], 8'h00);
    chk("t6_b1", bytes_b[1], 8'h00);
    chk("t6_spacing", stamp_b[1] - stamp_b[0], 2);
    step();
    chk("t6_rst_valid", tx_valid_b, 0);
    chk("t6_rst_ready", ready_b,    1);
    step();
    rst_b = 1'b1;
    repeat (20) step();
    chk("t6_no_more_strobes", bytes_b.size(), 2);
    chk("t6_idle",            idle_b,         1);
    chk("t6_data_cleared",    tx_data_b,      0);

    // Registers cleared by reset, then a full MSB-first transfer
    issue_b(sb(3'd5));
    wait_b(6);
    for (int i = 0; i < 4; i++) chk($sformatf("t6_zero_b%0d", i), bytes_b[2 + i], 8'h00);
    issue_b(pb(3'd5, 6'd12));
    issue_b(sb(3'd5));
    wait_b(10);
    exp4 = '{8'h00, 8'h00, 8'h00, 8'h0C};
    for (int i = 0; i < 4; i++) chk($sformatf("t6_msb_b%0d", i), bytes_b[6 + i], exp4[i]);
    chk("t6_msb_spacing", stamp_b[9] - stamp_b[8], 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
